vedic_mult_pipe: RTL
====================

Name: vedic_mult_pipe

Overview:
Parametrised, fully pipelined WIDTH x WIDTH multiplier built from four half-width partial-product multipliers.
- Accepts one operand pair per cycle through a valid/ready handshake.
- Supports a per-transaction signed/unsigned mode.
- Carries a user tag alongside each product.
- Applies backpressure from the consumer; a valid flag is emitted with each product, not inferred from output changes.
- Serves as the multiply engine for the matrix-multiplier datapath.

Parameters:
WIDTH, 32, operand width; must be even and >= 4; result is 2*WIDTH.
TAG_W, 8, width of the sideband tag carried with each operation.

Ports:
clk  input  1  clock, all state on rising edge.
reset  input  1  asynchronous, active-high; clears all pipeline state.
in_valid  input  1  operand pair presented.
in_ready  output  1  block can accept this cycle.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
in_tag  input  TAG_W  sideband, returned unchanged with result.
out_valid  output  1  result/out_tag valid.
out_ready  input  1  consumer accepts this cycle.
result  output  2*WIDTH  product (two's complement when signed_mode was 1).
out_tag  output  TAG_W  tag of the transaction in result.
busy  output  1  any pipeline stage holds a valid token.

Behaviour:
Reset (async assert, sync release):
- All stage valid bits, result, out_tag and out_valid go to 0.
- busy = 0; in_ready = 0 while reset is high.
- Reset mid-operation discards all in-flight tokens; no partial result is ever presented.

Pipeline: 4 stages; latency is exactly 4 cycles from the accept edge to out_valid when out_ready stays high.
- S1: register operands, mode and tag.
  - If signed_mode, take magnitudes |a| and |b| (WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1)).
  - Record neg = a_msb XOR b_msb.
  - If unsigned, neg = 0 and operands pass through.
- S2: compute and register four WIDTH/2 x WIDTH/2 partial products ll, hl, lh, hh.
- S3: register mid = hl + lh (WIDTH+1 bits, carry kept), plus ll and hh.
- S4: register p = {hh, ll} + (mid << WIDTH/2), truncated to 2*WIDTH bits; result = neg ? -p : p.

Handshake:
- advance = !s4_valid || out_ready.
- in_ready = advance (combinational, 0 during reset).
- Accept occurs when in_valid && in_ready.
- On advance every stage shifts by one; stage valid bits shift with data, and a bubble is inserted when no accept happens.
- When !advance the entire pipeline holds; result, out_tag and out_valid remain stable until taken.
- A transfer completes when out_valid && out_ready.
- Simultaneous accept and output transfer in one cycle are permitted, so sustained throughput is 1/cycle.

Ordering and bubbles:
- Results emerge strictly in acceptance order.
- Bubbles propagate without changing the held result register; result updates only when a valid token enters S4.

Width rules:
- No overflow is possible; the full 2*WIDTH product is always exact.
- In unsigned mode the maximum is (2^WIDTH-1)^2.
- In signed mode the product of two -2^(WIDTH-1) values is +2^(2*WIDTH-2), which is representable.

busy = OR of the S1..S4 valid bits.

Decomposition:
- Shared package (mult_pkg): localparams for the stage count (MULT_LAT = 4), function clog2, and the result-width helper (2*WIDTH).
- Sub-module vedic_half_mult: one parametrised combinational N x N unsigned multiplier (N = WIDTH/2), instantiated four times in S2.
- Stage registers, handshake and sign logic live in the top module.

Test Plan:
1. Unsigned, WIDTH=32: a=0xFFFFFFFF, b=0xFFFFFFFF, tag=0x5A -> after 4 cycles out_valid=1, result=0xFFFFFFFE00000001, out_tag=0x5A.
2. Signed: a=0xFFFFFFFD (-3), b=0x00000007 -> result=0xFFFFFFFFFFFFFFEB (-21). Then a=b=0x80000000 -> result=0x4000000000000000.
3. Back-to-back streaming: 16 random pairs on consecutive cycles with out_ready=1 -> 16 results on consecutive cycles, in order, matching the reference model, tags intact.
4. Backpressure: stream 6 ops and hold out_ready=0 for 5 cycles from the first out_valid -> in_ready drops, result/out_tag stable, no loss or duplication. After release, all 6 results appear in order.
5. Reset mid-flight: accept 3 ops, assert reset for 1 cycle asynchronously between edges -> out_valid, busy and result are 0 immediately. No stale result appears after release; the next op completes in 4 cycles.
6. Parameter sweep: WIDTH=8, TAG_W=1 -> a=0x80, b=0x80 signed gives 0x4000; unsigned a=0xFF, b=0x02 gives 0x01FE.

Source files
------------

// File: rtl/vedic_mult_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared constants and elaboration-time helpers for the pipelined
//            Vedic multiplier (stage count, log2, result width).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Number of register stages between the accept edge and out_valid.
    localparam int MULT_LAT = 4;

    // Ceiling log2, usable in constant expressions. clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Full-precision product width for a WIDTH x WIDTH multiply.
    function automatic int res_width(input int width);
        return 2 * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vedic_mult_pipe_half_mult.sv
`default_nettype none
// ============================================================================
// Module   : vedic_half_mult
// Purpose  : Combinational N x N unsigned multiplier using the Urdhva
//            Tiryagbhyam ("vertically and crosswise") column method: each
//            product column k sums every a[i]&b[j] with i+j == k plus the
//            carry from column k-1.
// Ports    : a_i [N-1:0]   multiplicand
//            b_i [N-1:0]   multiplier
//            p_o [2N-1:0]  exact unsigned product
// Revision : 1.0 - initial release
// ============================================================================
module vedic_half_mult
    import mult_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o
);

    // A column holds at most N crosswise bits plus an incoming carry that is
    // itself bounded by N, so 2N fits comfortably in this width.
    localparam int CW = clog2(N) + 3;

    logic [CW-1:0] w_col;
    logic [CW-1:0] w_carry;

    always_comb begin
        p_o     = '0;
        w_col   = '0;
        w_carry = '0;
        for (int k = 0; k < 2*N-1; k++) begin
            w_col = w_carry;
            for (int i = 0; i < N; i++) begin
                int j;
                j = k - i;
                if (j >= 0 && j < N) begin
                    w_col = w_col + CW'(a_i[i] & b_i[j]);
                end
            end
            p_o[k]  = w_col[0];
            w_carry = w_col >> 1;
        end
        // The product fits in 2N bits, so the final carry is a single bit.
        p_o[2*N-1] = w_carry[0];
    end

endmodule
`default_nettype wire

// File: rtl/vedic_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : vedic_mult_pipe
// Purpose  : Four-stage pipelined WIDTH x WIDTH multiplier with per-operation
//            signed/unsigned mode, sideband tag and valid/ready flow control.
//            The product is formed from four WIDTH/2 partial products.
//              S1: operand magnitudes + sign of the product
//              S2: four half-width partial products ll, hl, lh, hh
//              S3: mid = hl + lh (carry kept), ll, hh
//              S4: p = {hh,ll} + (mid << WIDTH/2), negated if needed
// Ports    : clk          clock, rising edge
//            reset        asynchronous active-high reset
//            in_valid     operand pair presented
//            in_ready     pipeline can accept this cycle
//            a, b         operands [WIDTH-1:0]
//            signed_mode  1 = two's-complement operands
//            in_tag       sideband tag [TAG_W-1:0]
//            out_valid    result/out_tag valid
//            out_ready    consumer accepts this cycle
//            result       product [2*WIDTH-1:0]
//            out_tag      tag of the product in result
//            busy         any stage holds a valid token
// Revision : 1.0 - initial release
// ============================================================================
module vedic_mult_pipe
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,   // must be even and >= 4
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    localparam int HALF  = WIDTH / 2;
    localparam int RES_W = res_width(WIDTH);

    // ------------------------------------------------------------------
    // Handshake: the whole pipeline moves as one unit whenever the output
    // slot is empty or being drained this cycle.
    // ------------------------------------------------------------------
    logic w_advance;
    logic w_accept;
    logic s4_valid_q;

    assign w_advance = !s4_valid_q || out_ready;
    assign in_ready  = w_advance && !reset;
    assign w_accept  = in_valid && in_ready;

    // ------------------------------------------------------------------
    // S1: magnitudes and product sign
    // ------------------------------------------------------------------
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic             s1_neg_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] s1_a_d, s1_b_d;
    logic             s1_neg_d;

    // Negating -2^(WIDTH-1) wraps back to the same bit pattern, which read
    // as unsigned is exactly the required magnitude 2^(WIDTH-1).
    always_comb begin
        w_a_neg  = signed_mode && a[WIDTH-1];
        w_b_neg  = signed_mode && b[WIDTH-1];
        s1_a_d   = w_a_neg ? (~a + WIDTH'(1)) : a;
        s1_b_d   = w_b_neg ? (~b + WIDTH'(1)) : b;
        s1_neg_d = w_a_neg ^ w_b_neg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_neg_q   <= 1'b0;
            s1_tag_q   <= '0;
        end else if (w_advance) begin
            s1_valid_q <= w_accept;
            if (w_accept) begin
                s1_a_q   <= s1_a_d;
                s1_b_q   <= s1_b_d;
                s1_neg_q <= s1_neg_d;
                s1_tag_q <= in_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: four half-width partial products
    //   index 0: ll = a_lo*b_lo   1: hl = a_hi*b_lo
    //   index 2: lh = a_lo*b_hi   3: hh = a_hi*b_hi
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_pp [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_pp
        logic [HALF-1:0] w_a_half;
        logic [HALF-1:0] w_b_half;

        assign w_a_half = (gi % 2 == 1) ? s1_a_q[WIDTH-1:HALF] : s1_a_q[HALF-1:0];
        assign w_b_half = (gi / 2 == 1) ? s1_b_q[WIDTH-1:HALF] : s1_b_q[HALF-1:0];

        vedic_half_mult #(
            .N (HALF)
        ) u_half_mult (
            .a_i (w_a_half),
            .b_i (w_b_half),
            .p_o (w_pp[gi])
        );
    end

    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_ll_q, s2_hl_q, s2_lh_q, s2_hh_q;
    logic             s2_neg_q;
    logic [TAG_W-1:0] s2_tag_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_ll_q    <= '0;
            s2_hl_q    <= '0;
            s2_lh_q    <= '0;
            s2_hh_q    <= '0;
            s2_neg_q   <= 1'b0;
            s2_tag_q   <= '0;
        end else if (w_advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_ll_q  <= w_pp[0];
                s2_hl_q  <= w_pp[1];
                s2_lh_q  <= w_pp[2];
                s2_hh_q  <= w_pp[3];
                s2_neg_q <= s1_neg_q;
                s2_tag_q <= s1_tag_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: sum the two cross terms, keeping the carry
    // ------------------------------------------------------------------
    logic             s3_valid_q;
    logic [WIDTH:0]   s3_mid_q;
    logic [WIDTH-1:0] s3_ll_q, s3_hh_q;
    logic             s3_neg_q;
    logic [TAG_W-1:0] s3_tag_q;
    logic [WIDTH:0]   s3_mid_d;

    assign s3_mid_d = {1'b0, s2_hl_q} + {1'b0, s2_lh_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_valid_q <= 1'b0;
            s3_mid_q   <= '0;
            s3_ll_q    <= '0;
            s3_hh_q    <= '0;
            s3_neg_q   <= 1'b0;
            s3_tag_q   <= '0;
        end else if (w_advance) begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_mid_q <= s3_mid_d;
                s3_ll_q  <= s2_ll_q;
                s3_hh_q  <= s2_hh_q;
                s3_neg_q <= s2_neg_q;
                s3_tag_q <= s2_tag_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // S4: final recombination and sign restore. The result register only
    // loads when a real token arrives, so bubbles leave it untouched.
    // ------------------------------------------------------------------
    logic [RES_W-1:0] w_p;
    logic [RES_W-1:0] s4_result_d;
    logic [RES_W-1:0] s4_result_q;
    logic [TAG_W-1:0] s4_tag_q;

    always_comb begin
        w_p         = {s3_hh_q, s3_ll_q} + (RES_W'(s3_mid_q) << HALF);
        s4_result_d = s3_neg_q ? (~w_p + RES_W'(1)) : w_p;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s4_valid_q  <= 1'b0;
            s4_result_q <= '0;
            s4_tag_q    <= '0;
        end else if (w_advance) begin
            s4_valid_q <= s3_valid_q;
            if (s3_valid_q) begin
                s4_result_q <= s4_result_d;
                s4_tag_q    <= s3_tag_q;
            end
        end
    end

    assign out_valid = s4_valid_q;
    assign result    = s4_result_q;
    assign out_tag   = s4_tag_q;
    assign busy      = s1_valid_q | s2_valid_q | s3_valid_q | s4_valid_q;

endmodule
`default_nettype wire
